// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_W = 8
);
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              memAck;
  logic [31:0]       memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata,
    output memAck, memRdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: sequences variable-latency data-memory accesses, stalls
// upstream while an access is pending, loads MEM/WB and issues branch redirects.
module mem_access_stage #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inBranchTaken,
  input  logic [7:0]  inBranchTarget,
  input  logic        inMemToReg,
  input  logic        inRegWrite,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [31:0] inALUResult,
  input  logic [31:0] inWriteData,
  input  logic [4:0]  inWriteReg,
  output logic        stall,
  output logic        pcRedirect,
  output logic [7:0]  pcTarget,
  output logic        outMemToReg,
  output logic        outRegWrite,
  output logic [31:0] outReadData,
  output logic [31:0] outALUResult,
  output logic [4:0]  outWriteReg,
  output logic        memErr,
  mem_access_stage_if.master mem
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_err_q, mem_err_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic                reg_write_q, reg_write_d;
  logic [31:0]         read_data_q, read_data_d;
  logic [31:0]         alu_result_q, alu_result_d;
  logic [4:0]          write_reg_q, write_reg_d;
  logic                pc_redirect_q, pc_redirect_d;
  logic [7:0]          pc_target_q, pc_target_d;
  logic                access;
  logic                timeout;
  logic                stall_c;

  always_comb begin
    access       = inMemRead | inMemWrite;
    timeout      = 1'b0;
    stall_c      = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_err_d    = mem_err_q;
    // MEM/WB defaults to a bubble; each retiring path overrides it
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    read_data_d  = '0;
    alu_result_d = '0;
    write_reg_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          stall_c     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = inMemWrite;
          mem_addr_d  = inALUResult[ADDR_W+1:2];
          mem_wdata_d = inWriteData;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end else begin
          mem_to_reg_d = inMemToReg;
          reg_write_d  = inRegWrite;
          alu_result_d = inALUResult;
          write_reg_d  = inWriteReg;
        end
      end
      S_WAIT: begin
        // an ack arriving in the last allowed cycle beats the timeout
        timeout = (cnt_q == CNT_W'(TIMEOUT - 1)) && !mem.memAck;
        stall_c = !mem.memAck && !timeout;
        if (mem.memAck) begin
          mem_req_d    = 1'b0;
          mem_to_reg_d = inMemToReg;
          reg_write_d  = inRegWrite;
          read_data_d  = mem_we_q ? 32'd0 : mem.memRdata;
          alu_result_d = inALUResult;
          write_reg_d  = inWriteReg;
          state_d      = S_IDLE;
        end else if (timeout) begin
          mem_req_d    = 1'b0;
          mem_err_d    = 1'b1;
          alu_result_d = inALUResult;
          write_reg_d  = inWriteReg;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) stall_c = 1'b0;

    // redirect only when the branch actually leaves EX/MEM, so a held branch fires once
    pc_redirect_d = inBranchTaken && !stall_c;
    pc_target_d   = stall_c ? pc_target_q : inBranchTarget;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_err_q     <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      read_data_q   <= '0;
      alu_result_q  <= '0;
      write_reg_q   <= '0;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_err_q     <= mem_err_d;
      mem_to_reg_q  <= mem_to_reg_d;
      reg_write_q   <= reg_write_d;
      read_data_q   <= read_data_d;
      alu_result_q  <= alu_result_d;
      write_reg_q   <= write_reg_d;
      pc_redirect_q <= pc_redirect_d;
      pc_target_q   <= pc_target_d;
    end
  end

  assign stall        = stall_c;
  assign pcRedirect   = pc_redirect_q;
  assign pcTarget     = pc_target_q;
  assign outMemToReg  = mem_to_reg_q;
  assign outRegWrite  = reg_write_q;
  assign outReadData  = read_data_q;
  assign outALUResult = alu_result_q;
  assign outWriteReg  = write_reg_q;
  assign memErr       = mem_err_q;
  assign mem.memReq   = mem_req_q;
  assign mem.memWe    = mem_we_q;
  assign mem.memAddr  = mem_addr_q;
  assign mem.memWdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues directed instructions and
// pushes hand-computed expectations; a monitor pops and checks each retirement.
module tb_mem_access_stage;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inBranchTaken = 1'b0;
  logic [7:0]  inBranchTarget = '0;
  logic        inMemToReg = 1'b0;
  logic        inRegWrite = 1'b0;
  logic        inMemRead = 1'b0;
  logic        inMemWrite = 1'b0;
  logic [31:0] inALUResult = '0;
  logic [31:0] inWriteData = '0;
  logic [4:0]  inWriteReg = '0;
  logic        stall, pcRedirect, outMemToReg, outRegWrite, memErr;
  logic [7:0]  pcTarget;
  logic [31:0] outReadData, outALUResult;
  logic [4:0]  outWriteReg;
  logic        tb_valid = 1'b0;
  logic        err_sticky = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_access_stage_if #(.ADDR_W(8)) mbus ();

  mem_access_stage #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .inBranchTaken(inBranchTaken), .inBranchTarget(inBranchTarget),
    .inMemToReg(inMemToReg), .inRegWrite(inRegWrite),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .inALUResult(inALUResult), .inWriteData(inWriteData), .inWriteReg(inWriteReg),
    .stall(stall), .pcRedirect(pcRedirect), .pcTarget(pcTarget),
    .outMemToReg(outMemToReg), .outRegWrite(outRegWrite),
    .outReadData(outReadData), .outALUResult(outALUResult),
    .outWriteReg(outWriteReg), .memErr(memErr),
    .mem(mbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        access;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        redirect;
    logic [7:0]  target;
    logic        err;
    int          stalls;
    int          req_cycles;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one instruction starting at posedge+1; returns at posedge+1 after it retires.
  // n_wait = WAIT cycles without ack before the ack cycle, -1 = never acked.
  task automatic op(input string nm, input logic br, input logic [7:0] tgt,
                    input logic mtr, input logic rw, input logic mr, input logic mw,
                    input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                    input int n_wait, input logic [31:0] rdata, input logic stray_ack,
                    input int exp_stalls, input logic [31:0] exp_rdata,
                    input logic [7:0] exp_addr);
    exp_t e;
    logic acc;
    acc = mr | mw;
    e.name       = nm;
    e.access     = acc;
    e.reg_write  = (acc && n_wait < 0) ? 1'b0 : rw;
    e.mem_to_reg = (acc && n_wait < 0) ? 1'b0 : mtr;
    e.read_data  = exp_rdata;
    e.alu        = alu;
    e.wreg       = rd;
    e.redirect   = br;
    e.target     = tgt;
    if (acc && n_wait < 0) err_sticky = 1'b1;
    e.err        = err_sticky;
    e.stalls     = exp_stalls;
    e.req_cycles = !acc ? 0 : (n_wait < 0 ? TIMEOUT : n_wait + 1);
    e.we         = mw;
    e.addr       = exp_addr;
    e.wdata      = wd;
    exp_q.push_back(e);

    tb_valid = 1'b1;
    inBranchTaken = br; inBranchTarget = tgt; inMemToReg = mtr; inRegWrite = rw;
    inMemRead = mr; inMemWrite = mw; inALUResult = alu; inWriteData = wd; inWriteReg = rd;
    if (!acc) begin
      if (stray_ack) begin mbus.memAck = 1'b1; mbus.memRdata = rdata; end
      @(posedge clk); #1;
      mbus.memAck = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (n_wait < 0) begin
        repeat (TIMEOUT) begin @(posedge clk); #1; end
      end else begin
        repeat (n_wait) begin @(posedge clk); #1; end
        mbus.memAck = 1'b1; mbus.memRdata = rdata;
        @(posedge clk); #1;
        mbus.memAck = 1'b0; mbus.memRdata = '0;
      end
    end
  endtask

  task automatic idle_inputs();
    tb_valid = 1'b0;
    inBranchTaken = 0; inBranchTarget = '0; inMemToReg = 0; inRegWrite = 0;
    inMemRead = 0; inMemWrite = 0; inALUResult = '0; inWriteData = '0; inWriteReg = '0;
  endtask

  // Monitor: counts stall/request cycles of the current instruction, checks on retirement.
  initial begin
    bit pend = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    logic [7:0]  cap_addr = '0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_wdata = '0;
    logic        unstable = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; stall_cnt = 0; req_cnt = 0; unstable = 1'b0;
      end else begin
        if (pend) begin
          pend = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_retire", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_regwrite"},  32'(outRegWrite), 32'(e.reg_write));
            chk({e.name, "_memtoreg"},  32'(outMemToReg), 32'(e.mem_to_reg));
            chk({e.name, "_readdata"},  outReadData, e.read_data);
            chk({e.name, "_aluresult"}, outALUResult, e.alu);
            chk({e.name, "_writereg"},  32'(outWriteReg), 32'(e.wreg));
            chk({e.name, "_redirect"},  32'(pcRedirect), 32'(e.redirect));
            chk({e.name, "_target"},    32'(pcTarget), 32'(e.target));
            chk({e.name, "_memerr"},    32'(memErr), 32'(e.err));
            chk({e.name, "_stalls"},    32'(stall_cnt), 32'(e.stalls));
            chk({e.name, "_reqcycles"}, 32'(req_cnt), 32'(e.req_cycles));
            chk({e.name, "_reqdrop"},   32'(mbus.memReq), 32'd0);
            if (e.access) begin
              chk({e.name, "_addr"},     32'(cap_addr), 32'(e.addr));
              chk({e.name, "_we"},       32'(cap_we), 32'(e.we));
              chk({e.name, "_busstable"}, 32'(unstable), 32'd0);
              if (e.we) chk({e.name, "_wdata"}, cap_wdata, e.wdata);
            end
            $display("txn %s retired: rw=%0d m2r=%0d rdata=0x%0h alu=0x%0h rd=%0d redir=%0d tgt=0x%0h err=%0d stalls=%0d",
                     e.name, outRegWrite, outMemToReg, outReadData, outALUResult,
                     outWriteReg, pcRedirect, pcTarget, memErr, stall_cnt);
          end
          stall_cnt = 0; req_cnt = 0; unstable = 1'b0;
        end else begin
          chk("redirect_idle_zero", 32'(pcRedirect), 32'd0);
        end
        if (tb_valid) begin
          if (stall) stall_cnt++;
          else pend = 1;
          if (mbus.memReq) begin
            if (req_cnt > 0 && (cap_addr != mbus.memAddr || cap_we != mbus.memWe ||
                                cap_wdata != mbus.memWdata)) unstable = 1'b1;
            cap_addr = mbus.memAddr; cap_we = mbus.memWe; cap_wdata = mbus.memWdata;
            req_cnt++;
          end
        end
      end
    end
  end

  initial begin
    mbus.memAck = 1'b0;
    mbus.memRdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_memreq", 32'(mbus.memReq), 32'd0);
    chk("rst_regwrite", 32'(outRegWrite), 32'd0);
    chk("rst_memerr", 32'(memErr), 32'd0);
    chk("rst_redirect", 32'(pcRedirect), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    //  name        br tgt    m2r rw mr mw alu           wd            rd  nwait rdata         stray stalls exp_rdata     addr
    op("alu_rd5",   0, 8'h00, 0, 1, 0, 0, 32'h1234,     32'h0,        5,  0,    32'h0,        0,    0,     32'h0,        8'h00);
    op("load10",    0, 8'h00, 1, 1, 1, 0, 32'h10,       32'h0,        7,  3,    32'hCAFEF00D, 0,    4,     32'hCAFEF00D, 8'h04);
    op("store20",   0, 8'h00, 0, 0, 0, 1, 32'h20,       32'hA5A5A5A5, 0,  0,    32'h0,        0,    1,     32'h0,        8'h08);
    op("ack_last",  0, 8'h00, 1, 1, 1, 0, 32'h44,       32'h0,        9,  14,   32'h12345678, 0,    15,    32'h12345678, 8'h11);
    op("timeout",   0, 8'h00, 1, 1, 1, 0, 32'h80,       32'h0,        10, -1,   32'h0,        0,    15,    32'h0,        8'h20);
    op("branch3c",  1, 8'h3C, 0, 0, 0, 0, 32'h0,        32'h0,        0,  0,    32'h0,        0,    0,     32'h0,        8'h00);
    op("rd_and_wr", 0, 8'h00, 0, 0, 1, 1, 32'h0C,       32'h0BADBEEF, 3,  1,    32'hFFFFFFFF, 0,    2,     32'h0,        8'h03);
    op("stray_ack", 0, 8'h77, 0, 1, 0, 0, 32'hDEADBEEF, 32'h0,        31, 0,    32'h55,       1,    0,     32'h0,        8'h00);

    // Reset in the middle of a pending load: nothing retires, outputs clear immediately.
    tb_valid = 1'b0;
    inMemRead = 1'b1; inRegWrite = 1'b1; inMemToReg = 1'b1; inALUResult = 32'h40;
    inWriteReg = 5'd2; inBranchTaken = 1'b0; inBranchTarget = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_memreq", 32'(mbus.memReq), 32'd1);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_memreq", 32'(mbus.memReq), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_memerr", 32'(memErr), 32'd0);
    chk("async_rst_target", 32'(pcTarget), 32'd0);
    chk("async_rst_regwrite", 32'(outRegWrite), 32'd0);
    idle_inputs();
    err_sticky = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    op("post_rst",  0, 8'h00, 0, 1, 0, 0, 32'h1,        32'h0,        1,  0,    32'h0,        0,    0,     32'h0,        8'h00);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
